// File: rtl/utf16_encoder.sv
// rtl/utf16_encoder.sv - Unicode scalar to UTF-16 code unit encoder with ready/valid handshakes
module utf16_encoder #(
    parameter bit REPLACE_INVALID = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [20:0] in_code_point,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_unit,
    output logic        out_last,
    output logic        out_error,
    input  logic        out_ready,
    output logic        error_pulse,
    output logic [15:0] unit_count
);

    typedef enum logic [1:0] {IDLE, SINGLE, HIGH, LOW} state_t;

    state_t      state;
    logic [9:0]  low_bits;
    logic        in_fire;
    logic        out_fire;
    logic        is_surrogate;
    logic        is_too_big;
    logic        is_supp;
    logic [19:0] v;

    assign out_fire = out_valid && out_ready;
    assign in_ready = (state == IDLE) || (out_fire && out_last);
    assign in_fire  = in_valid && in_ready;

    assign is_surrogate = (in_code_point[20:11] == 10'b00000_11011);
    assign is_too_big   = (in_code_point > 21'h10FFFF);
    assign is_supp      = (|in_code_point[20:16]) && !is_too_big;
    // Only the low 20 bits matter: for 0x10000..0x10FFFF the modular result equals cp-0x10000.
    assign v = in_code_point[19:0] - 20'h10000;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_unit    <= 16'h0000;
            out_last    <= 1'b0;
            out_error   <= 1'b0;
            error_pulse <= 1'b0;
            unit_count  <= 16'h0000;
            low_bits    <= 10'h000;
        end else begin
            error_pulse <= 1'b0;
            if (out_fire) begin
                unit_count <= unit_count + 16'd1;
            end
            if (in_fire) begin
                if (is_surrogate || is_too_big) begin
                    error_pulse <= 1'b1;
                    if (REPLACE_INVALID) begin
                        state     <= SINGLE;
                        out_valid <= 1'b1;
                        out_unit  <= 16'hFFFD;
                        out_last  <= 1'b1;
                        out_error <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_unit  <= 16'h0000;
                        out_last  <= 1'b0;
                        out_error <= 1'b0;
                    end
                end else if (is_supp) begin
                    state     <= HIGH;
                    out_valid <= 1'b1;
                    out_unit  <= 16'hD800 | {6'b000000, v[19:10]};
                    out_last  <= 1'b0;
                    out_error <= 1'b0;
                    low_bits  <= v[9:0];
                end else begin
                    state     <= SINGLE;
                    out_valid <= 1'b1;
                    out_unit  <= in_code_point[15:0];
                    out_last  <= 1'b1;
                    out_error <= 1'b0;
                end
            end else if (out_fire) begin
                if (state == HIGH) begin
                    // Low surrogate follows the high one with no idle cycle.
                    state     <= LOW;
                    out_unit  <= 16'hDC00 | {6'b000000, low_bits};
                    out_last  <= 1'b1;
                    out_error <= 1'b0;
                end else begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_unit  <= 16'h0000;
                    out_last  <= 1'b0;
                    out_error <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_utf16_encoder.sv
// tb/tb_utf16_encoder.sv - self-checking bench for utf16_encoder (table, corner sequences, random vs model)
module tb_utf16_encoder;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [20:0] in_code_point;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_unit;
    logic        out_last;
    logic        out_error;
    logic        out_ready;
    logic        error_pulse;
    logic [15:0] unit_count;

    logic        in_valid_b;
    logic [20:0] in_code_point_b;
    logic        in_ready_b;
    logic        out_valid_b;
    logic [15:0] out_unit_b;
    logic        out_last_b;
    logic        out_error_b;
    logic        out_ready_b;
    logic        error_pulse_b;
    logic [15:0] unit_count_b;

    int checks = 0;
    int errors = 0;

    utf16_encoder #(.REPLACE_INVALID(1'b1)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_code_point(in_code_point),
        .in_ready(in_ready), .out_valid(out_valid), .out_unit(out_unit), .out_last(out_last),
        .out_error(out_error), .out_ready(out_ready), .error_pulse(error_pulse),
        .unit_count(unit_count)
    );

    utf16_encoder #(.REPLACE_INVALID(1'b0)) dut_drop (
        .clock(clock), .reset(reset), .in_valid(in_valid_b), .in_code_point(in_code_point_b),
        .in_ready(in_ready_b), .out_valid(out_valid_b), .out_unit(out_unit_b),
        .out_last(out_last_b), .out_error(out_error_b), .out_ready(out_ready_b),
        .error_pulse(error_pulse_b), .unit_count(unit_count_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [20:0] cp;
        logic [15:0] hi;
        logic [15:0] lo;
        bit          two;
        bit          err;
    } vec_t;

    typedef struct {
        logic [15:0] unit;
        bit          last;
        bit          err;
    } unit_t;

    vec_t  vecs[13];
    unit_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_valid_b = 1'b0;
        out_ready = 1'b1;
        out_ready_b = 1'b1;
        #2 reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
    endtask

    // Reference: the UTF-16 units a single scalar should produce, plus whether it is invalid.
    function automatic bit model_push(input logic [20:0] cp);
        int   c;
        int   w;
        c = int'(cp);
        if ((c >= 32'hD800 && c <= 32'hDFFF) || c > 32'h10FFFF) begin
            exp_q.push_back('{16'hFFFD, 1'b1, 1'b1});
            return 1'b1;
        end
        if (c < 32'h10000) begin
            exp_q.push_back('{c[15:0], 1'b1, 1'b0});
        end else begin
            w = c - 32'h10000;
            exp_q.push_back('{16'(32'hD800 + w / 1024), 1'b0, 1'b0});
            exp_q.push_back('{16'(32'hDC00 + w % 1024), 1'b1, 1'b0});
        end
        return 1'b0;
    endfunction

    function automatic logic [20:0] gen_cp();
        case ($urandom_range(0, 5))
            0: return 21'($urandom_range(0, 32'h7F));
            1: return 21'($urandom_range(0, 32'hFFFF));
            2: return 21'($urandom_range(32'hD800, 32'hDFFF));
            3: return 21'($urandom_range(32'h10000, 32'h10FFFF));
            4: return 21'($urandom_range(32'h110000, 32'h1FFFFF));
            default: begin
                logic [20:0] edges [6];
                edges = '{21'hD7FF, 21'hE000, 21'hFFFF, 21'h10000, 21'h10FFFF, 21'h110000};
                return edges[$urandom_range(0, 5)];
            end
        endcase
    endfunction

    initial begin
        logic [15:0] exp_count;
        logic        in_fire;
        logic        out_fire;
        logic        was_invalid;
        logic        exp_pulse;

        vecs[0]  = '{21'h000000, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{21'h000041, 16'h0041, 16'h0000, 1'b0, 1'b0};
        vecs[2]  = '{21'h00D7FF, 16'hD7FF, 16'h0000, 1'b0, 1'b0};
        vecs[3]  = '{21'h00D800, 16'hFFFD, 16'h0000, 1'b0, 1'b1};
        vecs[4]  = '{21'h00DFFF, 16'hFFFD, 16'h0000, 1'b0, 1'b1};
        vecs[5]  = '{21'h00E000, 16'hE000, 16'h0000, 1'b0, 1'b0};
        vecs[6]  = '{21'h00FFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
        vecs[7]  = '{21'h010000, 16'hD800, 16'hDC00, 1'b1, 1'b0};
        vecs[8]  = '{21'h01F600, 16'hD83D, 16'hDE00, 1'b1, 1'b0};
        vecs[9]  = '{21'h010437, 16'hD801, 16'hDC37, 1'b1, 1'b0};
        vecs[10] = '{21'h10FFFF, 16'hDBFF, 16'hDFFF, 1'b1, 1'b0};
        vecs[11] = '{21'h110000, 16'hFFFD, 16'h0000, 1'b0, 1'b1};
        vecs[12] = '{21'h1FFFFF, 16'hFFFD, 16'h0000, 1'b0, 1'b1};

        reset = 1'b1;
        in_valid = 1'b0;
        in_code_point = 21'h0;
        out_ready = 1'b1;
        in_valid_b = 1'b0;
        in_code_point_b = 21'h0;
        out_ready_b = 1'b1;

        // Asynchronous reset before any clock edge
        #1 reset = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_unit", {16'd0, out_unit}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_out_error", {31'd0, out_error}, 32'd0);
        chk("rst_error_pulse", {31'd0, error_pulse}, 32'd0);
        chk("rst_unit_count", {16'd0, unit_count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        reset = 1'b1;
        #1;
        chk("in_ready_first_cycle", {31'd0, in_ready}, 32'd1);

        // Table vectors, one code point at a time with out_ready=1
        exp_count = 16'd0;
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1;
            in_code_point = vecs[i].cp;
            #1;
            chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            tick();
            in_valid = 1'b0;
            in_code_point = 21'h1ABCD;
            chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d_unit", i), {16'd0, out_unit}, {16'd0, vecs[i].hi});
            chk($sformatf("v%0d_last", i), {31'd0, out_last}, {31'd0, !vecs[i].two});
            chk($sformatf("v%0d_error", i), {31'd0, out_error}, {31'd0, vecs[i].err});
            chk($sformatf("v%0d_pulse", i), {31'd0, error_pulse}, {31'd0, vecs[i].err});
            if (vecs[i].two) begin
                chk($sformatf("v%0d_in_ready_high", i), {31'd0, in_ready}, 32'd0);
                tick();
                exp_count++;
                chk($sformatf("v%0d_lo_unit", i), {16'd0, out_unit}, {16'd0, vecs[i].lo});
                chk($sformatf("v%0d_lo_last", i), {31'd0, out_last}, 32'd1);
                chk($sformatf("v%0d_lo_pulse", i), {31'd0, error_pulse}, 32'd0);
            end
            tick();
            exp_count++;
            chk($sformatf("v%0d_idle", i), {31'd0, out_valid}, 32'd0);
            chk($sformatf("v%0d_count", i), {16'd0, unit_count}, {16'd0, exp_count});
        end

        // Back-pressure on a surrogate pair
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_code_point = 21'h010437;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_hi_unit_%0d", k), {16'd0, out_unit}, 32'hD801);
            chk($sformatf("bp_hi_valid_%0d", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp_hi_last_%0d", k), {31'd0, out_last}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        chk("bp_hi_still", {16'd0, out_unit}, 32'hD801);
        tick();
        chk("bp_lo_unit", {16'd0, out_unit}, 32'hDC37);
        chk("bp_lo_last", {31'd0, out_last}, 32'd1);
        tick();
        chk("bp_count", {16'd0, unit_count}, 32'd2);
        chk("bp_idle", {31'd0, out_valid}, 32'd0);

        // Back-to-back BMP stream
        do_reset();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_code_point = 21'(32'h41 + k);
            #1;
            chk($sformatf("stream_in_ready_%0d", k), {31'd0, in_ready}, 32'd1);
            tick();
            chk($sformatf("stream_unit_%0d", k), {16'd0, out_unit}, 32'h41 + k);
            chk($sformatf("stream_valid_%0d", k), {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_count", {16'd0, unit_count}, 32'd3);

        // Reset while the low surrogate is pending
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_code_point = 21'h01F600;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("low_state_unit", {16'd0, out_unit}, 32'hDE00);
        out_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("post_rst_valid_%0d", k), {31'd0, out_valid}, 32'd0);
        end
        chk("post_rst_count", {16'd0, unit_count}, 32'd0);

        // Dropping variant: invalid inputs produce pulses only
        do_reset();
        in_valid_b = 1'b1;
        in_code_point_b = 21'h00D800;
        #1;
        chk("drop_in_ready", {31'd0, in_ready_b}, 32'd1);
        tick();
        chk("drop_pulse_1", {31'd0, error_pulse_b}, 32'd1);
        chk("drop_valid_1", {31'd0, out_valid_b}, 32'd0);
        in_code_point_b = 21'h110000;
        tick();
        in_valid_b = 1'b0;
        chk("drop_pulse_2", {31'd0, error_pulse_b}, 32'd1);
        chk("drop_valid_2", {31'd0, out_valid_b}, 32'd0);
        tick();
        chk("drop_pulse_end", {31'd0, error_pulse_b}, 32'd0);
        chk("drop_count", {16'd0, unit_count_b}, 32'd0);

        // Random traffic against the reference model
        do_reset();
        exp_q.delete();
        exp_count = 16'd0;
        for (int c = 0; c < 3000; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_code_point = gen_cp();
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            in_fire = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (exp_q.size() == 0 && !in_ready) begin
                chk("rnd_in_ready_idle", {31'd0, in_ready}, 32'd1);
            end
            tick();
            if (out_fire && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                exp_count++;
            end
            exp_pulse = 1'b0;
            if (in_fire) begin
                was_invalid = model_push(in_code_point);
                exp_pulse = was_invalid;
            end
            chk("rnd_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                chk("rnd_unit", {16'd0, out_unit}, {16'd0, exp_q[0].unit});
                chk("rnd_last", {31'd0, out_last}, {31'd0, exp_q[0].last});
                chk("rnd_error", {31'd0, out_error}, {31'd0, exp_q[0].err});
            end
            chk("rnd_pulse", {31'd0, error_pulse}, {31'd0, exp_pulse});
            chk("rnd_count", {16'd0, unit_count}, {16'd0, exp_count});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/utf16_encoder.md
UTF16_ENCODER -- requirements
Module: utf16_encoder

Interface
REQ-001 Parameter: REPLACE_INVALID, default 1, meaning 1 = invalid code point emits U+FFFD with out_error=1, and 0 = invalid code point is dropped and only error_pulse is raised.
REQ-002 Port: clock, input, 1, sole clock; all state updates on its rising edge.
REQ-003 Port: reset, input, 1, asynchronous active-low reset.
REQ-004 Port: in_valid, input, 1, in_code_point is valid (driven from the decoder on STATUS_READY).
REQ-005 Port: in_code_point, input, 21, Unicode scalar to encode.
REQ-006 Port: in_ready, output, 1, block accepts in_code_point this cycle.
REQ-007 Port: out_valid, output, 1, out_unit holds a valid UTF-16 code unit.
REQ-008 Port: out_unit, output, 16, UTF-16 code unit.
REQ-009 Port: out_last, output, 1, out_unit is the final unit of the current code point.
REQ-010 Port: out_error, output, 1, out_unit is a replacement for an invalid input.
REQ-011 Port: out_ready, input, 1, downstream accepts out_unit this cycle.
REQ-012 Port: error_pulse, output, 1, one-cycle pulse per invalid input accepted.
REQ-013 Port: unit_count, output, 16, number of code units transferred since reset, wrapping.

Function
REQ-014 An input transfer SHALL occur when in_valid=1 and in_ready=1 on a rising edge; an output transfer SHALL occur when out_valid=1 and out_ready=1.
REQ-015 The FSM SHALL have states IDLE, SINGLE, HIGH and LOW.
REQ-016 in_ready SHALL be combinational and equal to (state==IDLE) or (out_valid and out_ready and out_last), allowing back-to-back BMP code points at one per cycle.
REQ-017 The first output unit SHALL be registered and present on out_valid one cycle after the input transfer (latency 1).
REQ-018 Input with code_point <= 0xFFFF and outside 0xD800..0xDFFF SHALL go to SINGLE with out_unit=code_point[15:0] and out_last=1.
REQ-019 Input in 0x10000..0x10FFFF SHALL compute v=code_point-0x10000 (20 bits) and go to HIGH with out_unit=0xD800|v[19:10] and out_last=0; v[9:0] SHALL be held internally.
REQ-020 An output transfer in HIGH SHALL go to LOW with out_unit=0xDC00|v[9:0] and out_last=1, with no idle cycle between the two units.
REQ-021 Input in 0xD800..0xDFFF or greater than 0x10FFFF is invalid and SHALL pulse error_pulse on the cycle after acceptance.
REQ-022 With REPLACE_INVALID=1, an invalid input SHALL go to SINGLE with out_unit=0xFFFD, out_last=1 and out_error=1.
REQ-023 With REPLACE_INVALID=0, an invalid input SHALL stay in IDLE with no output.
REQ-024 out_error SHALL be 0 for every unit not produced by REQ-022.
REQ-025 While out_valid=1 and out_ready=0, out_unit, out_last, out_error and state SHALL hold stable.
REQ-026 out_valid SHALL never deassert without an output transfer.
REQ-027 An output transfer on a last unit with no simultaneous input transfer SHALL return the FSM to IDLE with out_valid=0.
REQ-028 When a last-unit output transfer and an input transfer occur on the same edge, the new input SHALL be loaded (REQ-018..REQ-023) with no bubble.
REQ-029 unit_count SHALL increment by 1 on every output transfer and wrap from 0xFFFF to 0x0000.
REQ-030 in_code_point SHALL be ignored when no input transfer occurs.

Reset
REQ-031 reset=0 SHALL immediately (asynchronously) force state=IDLE, out_valid=0, out_unit=0, out_last=0, out_error=0, error_pulse=0, unit_count=0 and the held low bits=0.
REQ-032 Reset asserted mid surrogate pair SHALL discard the pending low unit; no LOW unit SHALL appear after reset release.
REQ-033 After reset release, in_ready SHALL be 1 in the first cycle.

Verification
REQ-034 Input 0x41 with out_ready=1 -> next cycle out_unit=0x0041, out_last=1, out_error=0; unit_count=1.
REQ-035 Input 0x1F600 -> out_unit=0xD83D with out_last=0, then next cycle 0xDE00 with out_last=1; in_ready=0 during HIGH.
REQ-036 Inputs 0xD800 then 0x110000 with REPLACE_INVALID=1 -> two units 0xFFFD, each with out_error=1 and one error_pulse; with REPLACE_INVALID=0 -> no out_valid, two error_pulse.
REQ-037 Input 0x10437 with out_ready held 0 for 3 cycles -> out_unit=0xD801 stable for 3 cycles, then 0xDC37 after release; unit_count=2.
REQ-038 Stream 0x41, 0x42, 0x43 with continuous in_valid and out_ready=1 -> units on 3 consecutive cycles with in_ready=1 throughout.
REQ-039 reset=0 asserted while in LOW -> out_valid=0 asynchronously; after release no 0xDCxx unit appears and unit_count=0.
